// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the device over
//   the shared open-drain ps2_clk/ps2_data pair: inhibit, request-to-send,
//   ten device-clocked bits (8 data, odd parity, stop), then the ACK bit.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   tx_data       command byte, captured when tx_valid & tx_ready
//   tx_valid      byte offered
//   tx_ready      high only while idle
//   ps2_clk       raw PS/2 clock line level (asynchronous)
//   ps2_data      raw PS/2 data line level (asynchronous)
//   ps2_clk_oe    1 = pull ps2_clk low, 0 = release
//   ps2_data_oe   1 = pull ps2_data low, 0 = release
//   busy          high whenever not idle (gates the receive path)
//   done          one-cycle pulse: transfer finished, ack_ok valid
//   ack_ok        held: 1 = device pulled data low on the 11th clock edge
//   error         one-cycle pulse: watchdog expired, lines released
//
// Handshake: a byte is transferred on a rising clk edge where tx_valid and
// tx_ready are both high. tx_valid while tx_ready is low is ignored; nothing
// is latched or queued.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int START_TIMEOUT  = 1500000,
   parameter int XFER_TIMEOUT   = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error
);

   localparam int MAX_CNT =
      (INHIBIT_CYCLES > START_TIMEOUT)
         ? ((INHIBIT_CYCLES > XFER_TIMEOUT) ? INHIBIT_CYCLES : XFER_TIMEOUT)
         : ((START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT);
   localparam int CW = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] INH_LD   = CW'(INHIBIT_CYCLES);
   localparam logic [CW-1:0] START_LD = CW'(START_TIMEOUT);
   localparam logic [CW-1:0] XFER_LD  = CW'(XFER_TIMEOUT);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_REQ,
      S_SEND,
      S_ACK,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_n;
   logic [2:0]    sync_q;
   logic [1:0]    dsync_q;
   logic [CW-1:0] timer_q, timer_n;
   logic [9:0]    shift_q, shift_n;
   logic [3:0]    bit_cnt_q, bit_cnt_n;
   logic          clk_oe_q, clk_oe_n;
   logic          data_oe_q, data_oe_n;
   logic          tx_ready_q, tx_ready_n;
   logic          busy_q, busy_n;
   logic          done_q, done_n;
   logic          ack_ok_q, ack_ok_n;
   logic          error_q, error_n;

   logic fall;
   logic data_s;
   logic clk_s;
   logic timer_last;

   // A falling edge needs a high sample followed by a low one, so the host
   // releasing its own clock (low -> high) never looks like a device edge.
   assign fall       = sync_q[2] & ~sync_q[1];
   assign clk_s      = sync_q[1];
   assign data_s     = dsync_q[1];
   // One counter serves as the inhibit timer and the watchdog; both count
   // down and finish on the edge that would take them to zero.
   assign timer_last = (timer_q == ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= 3'b111;
         dsync_q    <= 2'b11;
         timer_q    <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_n;
         sync_q     <= {sync_q[1:0], ps2_clk};
         dsync_q    <= {dsync_q[0], ps2_data};
         timer_q    <= timer_n;
         shift_q    <= shift_n;
         bit_cnt_q  <= bit_cnt_n;
         clk_oe_q   <= clk_oe_n;
         data_oe_q  <= data_oe_n;
         tx_ready_q <= tx_ready_n;
         busy_q     <= busy_n;
         done_q     <= done_n;
         ack_ok_q   <= ack_ok_n;
         error_q    <= error_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      timer_n   = timer_q;
      shift_n   = shift_q;
      bit_cnt_n = bit_cnt_q;
      data_oe_n = data_oe_q;
      ack_ok_n  = ack_ok_q;

      case (state_q)
         S_IDLE: begin
            if (tx_valid && tx_ready_q) begin
               shift_n   = {1'b1, ~^tx_data, tx_data};
               bit_cnt_n = '0;
               timer_n   = INH_LD;
               state_n   = S_INHIBIT;
            end
         end

         // Device edges seen here are the echo of our own clock pull-down.
         S_INHIBIT: begin
            if (timer_last) begin
               state_n = S_RTS;
            end else begin
               timer_n = timer_q - ONE;
            end
         end

         S_RTS: begin
            timer_n = START_LD;
            state_n = S_REQ;
         end

         // The first device edge wins over a simultaneous watchdog expiry.
         S_REQ: begin
            if (fall) begin
               data_oe_n = ~shift_q[0];
               shift_n   = {1'b1, shift_q[9:1]};
               bit_cnt_n = 4'd1;
               timer_n   = XFER_LD;
               state_n   = S_SEND;
            end else if (timer_last) begin
               state_n = S_ERROR;
            end else begin
               timer_n = timer_q - ONE;
            end
         end

         // shift_q[0] always holds the bit for the next device edge; the
         // edge that carries the stop bit (count 9 -> 10) ends the phase.
         S_SEND: begin
            if (timer_last) begin
               state_n = S_ERROR;
            end else begin
               timer_n = timer_q - ONE;
               if (fall) begin
                  data_oe_n = ~shift_q[0];
                  shift_n   = {1'b1, shift_q[9:1]};
                  bit_cnt_n = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd9) begin
                     state_n = S_ACK;
                  end
               end
            end
         end

         S_ACK: begin
            if (timer_last) begin
               state_n = S_ERROR;
            end else begin
               timer_n = timer_q - ONE;
               if (fall) begin
                  ack_ok_n = ~data_s;
                  state_n  = S_RELEASE;
               end
            end
         end

         // Wait for the device to let go of both lines before reporting.
         S_RELEASE: begin
            if (timer_last) begin
               state_n = S_ERROR;
            end else begin
               timer_n = timer_q - ONE;
               if (clk_s && data_s) begin
                  state_n = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         S_ERROR: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (state_n == S_ERROR) begin
         ack_ok_n = 1'b0;
      end

      // Every output is a registered decode of the state being entered.
      case (state_n)
         S_RTS, S_REQ: data_oe_n = 1'b1;
         S_SEND:       data_oe_n = data_oe_n;
         default:      data_oe_n = 1'b0;
      endcase

      clk_oe_n   = (state_n == S_INHIBIT) || (state_n == S_RTS);
      tx_ready_n = (state_n == S_IDLE);
      busy_n     = (state_n != S_IDLE);
      done_n     = (state_n == S_DONE);
      error_n    = (state_n == S_ERROR);
   end

   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign ack_ok      = ack_ok_q;
   assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Bench for ps2_host_tx: a cycle-level PS/2 device model on a wired-AND
//   bus, a line-bit scoreboard filled from the byte-framing rules, and a
//   table of transfers plus hand-written timeout and abort sequences.

module tb_ps2_host_tx;

   localparam int INH = 100;
   localparam int STO = 1000;
   localparam int XTO = 5000;
   localparam int H   = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, ack_ok, error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_TIMEOUT  (STO),
      .XFER_TIMEOUT   (XTO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk     (ps2_clk_line),
      .ps2_data    (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .ack_ok      (ack_ok),
      .error       (error)
   );

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [0:0] exp_q[$];

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line bits the device must read: start 0, data LSB first, odd parity, stop 1.
   function automatic void push_expected(input logic [7:0] d);
      int ones;
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(d[i]);
         if (d[i]) ones++;
      end
      if (ones % 2 == 0) exp_q.push_back(1'b1);
      else               exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
   endfunction

   task automatic sb_sample(input logic v, input int idx);
      logic [0:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL line_bit%0d: got %b with no expected bit left", idx, v);
      end else begin
         e = exp_q.pop_front();
         check_bit($sformatf("line_bit%0d", idx), v, e[0]);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Offers a byte for one cycle and returns at the negedge of cycle 1.
   task automatic accept(input logic [7:0] d);
      @(negedge clk);
      check_bit("ready_before_accept", tx_ready, 1'b1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_bit("ready_after_accept", tx_ready, 1'b0);
      check_bit("busy_after_accept", busy, 1'b1);
   endtask

   task automatic wait_req(output bit ok);
      int t;
      t = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < INH + 20) begin
         @(negedge clk);
         t++;
      end
      ok = (t < INH + 20);
      if (!ok) check_int("wait_req_timeout", t, INH + 1);
   endtask

   // Device model: reads start at clock release, reads each bit at its own
   // rising edges, pulls data low before edge 11 when acking.
   task automatic device(input bit ack, input int n_edges);
      bit ok;
      wait_req(ok);
      if (ok) begin
         sb_sample(ps2_data_line, 0);
         repeat (20) @(negedge clk);
         for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) sb_sample(ps2_data_line, e);
            if (e == 10 && ack) begin
               repeat (H / 2) @(negedge clk);
               dev_data_low = 1'b1;
               repeat (H - H / 2) @(negedge clk);
            end else begin
               repeat (H) @(negedge clk);
            end
         end
         dev_data_low = 1'b0;
      end
   endtask

   task automatic run_xfer(input logic [7:0] d, input bit ack, input bit exp_ack);
      int inh, rts, t;
      exp_q.delete();
      push_expected(d);
      accept(d);
      fork
         device(ack, 11);
         begin
            inh = 0;
            while (ps2_clk_oe && !ps2_data_oe && inh < INH + 10) begin
               inh++;
               @(negedge clk);
            end
            check_int("inhibit_len", inh, INH);
            rts = 0;
            while (ps2_clk_oe && ps2_data_oe && rts < 5) begin
               rts++;
               @(negedge clk);
            end
            check_int("rts_len", rts, 1);
            check_bit("req_clk_oe", ps2_clk_oe, 1'b0);
            check_bit("req_data_oe", ps2_data_oe, 1'b1);
            // Offer a different byte mid-transfer; it must not be taken.
            tx_data  = ~d;
            tx_valid = 1'b1;
            @(negedge clk);
            check_bit("ready_while_busy", tx_ready, 1'b0);
            tx_valid = 1'b0;
            t = 0;
            while (!done && !error && t < XTO) begin
               @(negedge clk);
               t++;
            end
            check_bit("done_pulse", done, 1'b1);
            check_bit("no_error", error, 1'b0);
            check_bit("ack_ok", ack_ok, exp_ack);
            check_bit("busy_at_done", busy, 1'b1);
            @(negedge clk);
            check_bit("done_width", done, 1'b0);
            check_bit("ready_back", tx_ready, 1'b1);
            check_bit("busy_low", busy, 1'b0);
            check_bit("ack_ok_held", ack_ok, exp_ack);
         end
      join
      check_int("sb_leftover", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         exp_ack_ok;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int t;
      bit ok;
      bit done_seen;

      vecs[0] = '{8'hED, 1'b1, 1'b1};
      vecs[1] = '{8'h01, 1'b1, 1'b1};
      vecs[2] = '{8'h55, 1'b0, 1'b0};
      for (int i = 3; i < 8; i++) begin
         vecs[i].data       = 8'($urandom_range(0, 255));
         vecs[i].ack        = 1'($urandom_range(0, 1));
         vecs[i].exp_ack_ok = vecs[i].ack;
      end

      // Reset with a byte offered: nothing may be accepted.
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h12;
      repeat (4) @(negedge clk);
      check_bit("rst_clk_oe", ps2_clk_oe, 1'b0);
      check_bit("rst_data_oe", ps2_data_oe, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_ready", tx_ready, 1'b1);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_ack_ok", ack_ok, 1'b0);
      check_bit("rst_error", error, 1'b0);
      tx_valid = 1'b0;
      rst      = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("post_rst_ready", tx_ready, 1'b1);
      check_bit("post_rst_busy", busy, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_xfer(vecs[i].data, vecs[i].ack, vecs[i].exp_ack_ok);
      end

      // No device: error exactly STO cycles after the clock is released.
      run_xfer(8'hC3, 1'b1, 1'b1);
      accept(8'hAA);
      wait_req(ok);
      if (ok) begin
         t = 0;
         done_seen = 1'b0;
         while (!error && t < STO + 10) begin
            @(negedge clk);
            t++;
            if (done) done_seen = 1'b1;
         end
         check_int("timeout_cycles", t, STO);
         check_bit("timeout_error", error, 1'b1);
         check_bit("timeout_no_done", done_seen, 1'b0);
         check_bit("timeout_clk_oe", ps2_clk_oe, 1'b0);
         check_bit("timeout_data_oe", ps2_data_oe, 1'b0);
         check_bit("timeout_ack_cleared", ack_ok, 1'b0);
         check_bit("timeout_ready_low", tx_ready, 1'b0);
         @(negedge clk);
         check_bit("timeout_error_width", error, 1'b0);
         check_bit("timeout_ready_back", tx_ready, 1'b1);
      end

      // Abort by reset after device edge 4.
      run_xfer(8'hA5, 1'b1, 1'b1);
      accept(8'hED);
      wait_req(ok);
      if (ok) begin
         repeat (20) @(negedge clk);
         for (int e = 1; e <= 4; e++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (10) @(negedge clk);
         check_bit("abort_busy_before", busy, 1'b1);
         rst = 1'b1;
         #1;
         check_bit("abort_clk_oe", ps2_clk_oe, 1'b0);
         check_bit("abort_data_oe", ps2_data_oe, 1'b0);
         check_bit("abort_ack_ok", ack_ok, 1'b0);
         check_bit("abort_busy", busy, 1'b0);
         dev_clk_low  = 1'b0;
         dev_data_low = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         repeat (3) @(negedge clk);
      end
      run_xfer(8'hFF, 1'b1, 1'b1);

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
